sdes_key_schedule: RTL

//  Sequential S-DES subkey generator; the successor to the fixed P10/P8 permutation wiring.

---
 rtl/sdes_pkg.sv | 58 +++++
 rtl/sdes_key_schedule.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sdes_pkg.sv
// S-DES key-schedule types, permutation tables and helper functions.
// Purely combinational helpers; no state, no latency of their own.
// No flow control here; callers own the handshakes.
//
// Shared with the round datapath. Table entries are 1-based positions
// with position 1 at the MSB, so position p of a 10-bit word is bit 10-p.
package sdes_pkg;

    typedef logic [9:0] key_t;
    typedef logic [7:0] subkey_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam int unsigned P10_POS [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int unsigned P8_POS  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};

    // P10: output position i+1 takes input position P10_POS[i].
    function automatic key_t p10(input key_t k);
        key_t r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4'(9 - i)] = k[4'(10 - P10_POS[i])];
        end
        return r;
    endfunction

    // P8: selects and reorders 8 of the 10 rotated key bits.
    function automatic subkey_t p8(input key_t k);
        subkey_t r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[3'(7 - i)] = k[4'(10 - P8_POS[i])];
        end
        return r;
    endfunction

    // Rotate each 5-bit half left by sh (mod 5), independently.
    function automatic key_t rotl5x2(input key_t k, input int sh);
        logic [4:0] hi;
        logic [4:0] lo;
        int         s;
        hi = k[9:5];
        lo = k[4:0];
        s  = sh % 5;
        for (int j = 0; j < 4; j++) begin
            if (j < s) begin
                hi = {hi[3:0], hi[4]};
                lo = {lo[3:0], lo[4]};
            end
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/sdes_key_schedule.sv
// Sequential S-DES subkey generator: P10, then per round rotate + P8, streamed out.
// Latency: start accepted at edge T -> first subkey valid at edge T+NUM_ROUNDS+1.
// Backpressure: outputs hold while valid && !ready; index advances only on handshake.
//
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   i_start, i_key, i_decrypt    schedule request (accepted only when o_ready=1)
//   o_ready, o_busy              IDLE / GEN-or-EMIT status, registered
//   o_subkey, o_round_idx,
//   o_last, o_subkey_valid,
//   i_subkey_ready               subkey stream, valid/ready handshake
import sdes_pkg::*;

module sdes_key_schedule #(
    parameter int NUM_ROUNDS = 2,
    parameter int IDX_W      = $clog2(NUM_ROUNDS > 1 ? NUM_ROUNDS : 2)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [9:0]       i_key,
    input  logic             i_decrypt,
    output logic             o_ready,
    output logic             o_busy,
    output logic [7:0]       o_subkey,
    output logic             o_subkey_valid,
    input  logic             i_subkey_ready,
    output logic [IDX_W-1:0] o_round_idx,
    output logic             o_last
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 8) begin : g_cfg_err
        $error("sdes_key_schedule: NUM_ROUNDS must be in 1..8");
    end

    localparam logic [IDX_W-1:0] LAST_R = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);

    state_t           state_q;
    key_t             work_q;
    logic             dec_q;
    logic [IDX_W-1:0] rnd_q;
    logic [IDX_W-1:0] idx_q;
    subkey_t          store_q [NUM_ROUNDS];
    subkey_t          sub_q;
    logic             vld_q;
    logic             last_q;
    logic             ready_q;
    logic             busy_q;

    key_t             work_d;
    subkey_t          gen_key_d;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] end_idx;
    subkey_t          sel_cur;
    subkey_t          sel_nxt;

    // Round 0 rotates by 1; each later round adds 2 to the running rotation.
    always_comb begin
        work_d    = rotl5x2(work_q, (rnd_q == '0) ? 1 : 2);
        gen_key_d = p8(work_d);
    end

    // Read side: both the current and the next index are muxed so that the
    // registered output can be refilled on the same edge as a handshake.
    always_comb begin
        idx_d   = dec_q ? (idx_q - ONE) : (idx_q + ONE);
        end_idx = dec_q ? '0 : LAST_R;
        sel_cur = '0;
        sel_nxt = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (idx_q == IDX_W'(i)) sel_cur = store_q[i];
            if (idx_d == IDX_W'(i)) sel_nxt = store_q[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            dec_q   <= 1'b0;
            rnd_q   <= '0;
            idx_q   <= '0;
            sub_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            for (int i = 0; i < NUM_ROUNDS; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        work_q  <= p10(i_key);
                        dec_q   <= i_decrypt;
                        rnd_q   <= '0;
                        state_q <= GEN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                GEN: begin
                    work_q <= work_d;
                    for (int i = 0; i < NUM_ROUNDS; i++) begin
                        if (rnd_q == IDX_W'(i)) store_q[i] <= gen_key_d;
                    end
                    rnd_q <= rnd_q + ONE;
                    if (rnd_q == LAST_R) begin
                        state_q <= EMIT;
                        idx_q   <= dec_q ? LAST_R : '0;
                    end
                end

                EMIT: begin
                    if (!vld_q) begin
                        // First EMIT cycle primes the output register from the store.
                        vld_q  <= 1'b1;
                        sub_q  <= sel_cur;
                        last_q <= (idx_q == end_idx);
                    end else if (i_subkey_ready) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            vld_q   <= 1'b0;
                            last_q  <= 1'b0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q  <= idx_d;
                            sub_q  <= sel_nxt;
                            last_q <= (idx_d == end_idx);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready        = ready_q;
    assign o_busy         = busy_q;
    assign o_subkey       = sub_q;
    assign o_subkey_valid = vld_q;
    assign o_round_idx    = idx_q;
    assign o_last         = last_q;

endmodule
